// File: rtl/board_pkg.sv
// Shared constants for the board update block: sides, status codes, piece slots,
// default start-position vectors and FSM state encoding.
package board_pkg;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  localparam logic [1:0] ST_OK           = 2'd0;
  localparam logic [1:0] ST_WRONG_TURN   = 2'd1;
  localparam logic [1:0] ST_DEAD_PIECE   = 2'd2;
  localparam logic [1:0] ST_SELF_CAPTURE = 2'd3;

  // Piece slot indices, matching the default start vectors (K1 sits on square 4).
  localparam int K1 = 0;
  localparam int Q1 = 1;
  localparam int B1 = 2;
  localparam int B2 = 3;
  localparam int N1 = 4;
  localparam int N2 = 5;
  localparam int R1 = 6;
  localparam int R2 = 7;
  localparam int P1 = 8;
  localparam int P2 = 9;
  localparam int P3 = 10;
  localparam int P4 = 11;
  localparam int P5 = 12;
  localparam int P6 = 13;
  localparam int P7 = 14;
  localparam int P8 = 15;

  localparam logic [95:0] INIT_LOC_W_DEF = 96'h20928B30D38F0070460850C4;
  localparam logic [95:0] INIT_LOC_B_DEF = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_UNDO   = 3'd4;

  // Move legality in priority order: turn first, then liveness, then self-capture.
  function automatic logic [1:0] move_status(input logic wrong_turn,
                                             input logic piece_dead,
                                             input logic self_hit);
    if (wrong_turn)      return ST_WRONG_TURN;
    else if (piece_dead) return ST_DEAD_PIECE;
    else if (self_hit)   return ST_SELF_CAPTURE;
    else                 return ST_OK;
  endfunction

endpackage

// File: rtl/board_match_unit.sv
// Finds the live pieces of one side standing on a given square, optionally
// ignoring one piece, and reports the lowest matching index.
module board_match_unit
  import board_pkg::*;
#(
  parameter int NUM_PIECES = 16,
  parameter int SQ_W       = 6,
  localparam int IDX_W     = $clog2(NUM_PIECES)
) (
  input  logic [NUM_PIECES*SQ_W-1:0] loc,
  input  logic [NUM_PIECES-1:0]      alive,
  input  logic [SQ_W-1:0]            dst,
  input  logic [IDX_W-1:0]           excl_idx,
  input  logic                       excl_en,
  output logic [NUM_PIECES-1:0]      hit,
  output logic                       any_hit,
  output logic [IDX_W-1:0]           low_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIECES; gi++) begin : g_cmp
      // Dead pieces keep their stale square, so liveness gates every match.
      assign hit[gi] = alive[gi] && (loc[gi*SQ_W +: SQ_W] == dst) &&
                       !(excl_en && (excl_idx == IDX_W'(gi)));
    end
  endgenerate

  assign any_hit = |hit;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (hit[i]) low_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/board_update_gen.sv
// Board state register with validated, handshaked move commit and capture resolution.
// Optional one-level undo of the last accepted move when BOARD_UNDO_EN is defined.
module board_update_gen
  import board_pkg::*;
#(
  parameter int                          NUM_PIECES = 16,
  parameter int                          SQ_W       = 6,
  parameter logic [NUM_PIECES*SQ_W-1:0]  INIT_LOC_W = INIT_LOC_W_DEF,
  parameter logic [NUM_PIECES*SQ_W-1:0]  INIT_LOC_B = INIT_LOC_B_DEF,
  parameter int                          CNT_W      = 16,
  localparam int                         IDX_W      = $clog2(NUM_PIECES)
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic                       move_player,
  input  logic [IDX_W-1:0]           move_piece,
  input  logic [SQ_W-1:0]            move_dst,
`ifdef BOARD_UNDO_EN
  input  logic                       undo_req,
  output logic                       undo_ready,
`endif
  output logic [NUM_PIECES*SQ_W-1:0] loc_w,
  output logic [NUM_PIECES*SQ_W-1:0] loc_b,
  output logic [NUM_PIECES-1:0]      alive_w,
  output logic [NUM_PIECES-1:0]      alive_b,
  output logic                       turn,
  output logic                       done,
  output logic [1:0]                 status,
  output logic                       captured,
  output logic [IDX_W-1:0]           captured_idx,
  output logic [CNT_W-1:0]           ply_count,
  output logic [1:0]                 dbg_state
);

  logic [2:0]                 state_reg, state_next;
  logic                       player_reg;
  logic [IDX_W-1:0]           piece_reg;
  logic [SQ_W-1:0]            dst_reg;
  logic [1:0]                 chk_status_reg;
  logic                       cap_pend_reg;
  logic [IDX_W-1:0]           cap_idx_pend_reg;

  logic [NUM_PIECES*SQ_W-1:0] loc_w_reg, loc_b_reg;
  logic [NUM_PIECES-1:0]      alive_w_reg, alive_b_reg;
  logic                       turn_reg;
  logic [CNT_W-1:0]           ply_reg;
  logic [1:0]                 status_reg;
  logic                       captured_reg;
  logic [IDX_W-1:0]           captured_idx_reg;

`ifdef BOARD_UNDO_EN
  logic                       hist_valid_reg;
  logic                       hist_player_reg;
  logic [IDX_W-1:0]           hist_piece_reg;
  logic [SQ_W-1:0]            hist_old_sq_reg;
  logic                       hist_cap_reg;
  logic [IDX_W-1:0]           hist_cap_idx_reg;
`endif

  logic [NUM_PIECES*SQ_W-1:0] own_loc, opp_loc;
  logic [NUM_PIECES-1:0]      own_alive, opp_alive;
  logic [NUM_PIECES-1:0]      own_hit, opp_hit;
  logic                       own_any, opp_any;
  logic [IDX_W-1:0]           own_low_idx, opp_low_idx;
  logic [1:0]                 chk_status_next;
  logic                       match_unused;

  assign own_loc   = (player_reg == WHITE) ? loc_w_reg   : loc_b_reg;
  assign opp_loc   = (player_reg == WHITE) ? loc_b_reg   : loc_w_reg;
  assign own_alive = (player_reg == WHITE) ? alive_w_reg : alive_b_reg;
  assign opp_alive = (player_reg == WHITE) ? alive_b_reg : alive_w_reg;

  board_match_unit #(.NUM_PIECES(NUM_PIECES), .SQ_W(SQ_W)) u_own_match (
    .loc      (own_loc),
    .alive    (own_alive),
    .dst      (dst_reg),
    .excl_idx (piece_reg),
    .excl_en  (1'b1),
    .hit      (own_hit),
    .any_hit  (own_any),
    .low_idx  (own_low_idx)
  );

  board_match_unit #(.NUM_PIECES(NUM_PIECES), .SQ_W(SQ_W)) u_opp_match (
    .loc      (opp_loc),
    .alive    (opp_alive),
    .dst      (dst_reg),
    .excl_idx ({IDX_W{1'b0}}),
    .excl_en  (1'b0),
    .hit      (opp_hit),
    .any_hit  (opp_any),
    .low_idx  (opp_low_idx)
  );

  // Only the summary outputs of the match units drive decisions here.
  assign match_unused = ^{own_hit, own_low_idx, opp_hit};

  assign chk_status_next = move_status(player_reg != turn_reg,
                                       !own_alive[piece_reg],
                                       own_any);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (move_valid) state_next = S_CHECK;
`ifdef BOARD_UNDO_EN
        else if (undo_req) state_next = S_UNDO;
`endif
      end
      S_CHECK:  state_next = S_COMMIT;
      S_COMMIT: state_next = S_REPORT;
      S_UNDO:   state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg        <= S_IDLE;
      player_reg       <= WHITE;
      piece_reg        <= '0;
      dst_reg          <= '0;
      chk_status_reg   <= ST_OK;
      cap_pend_reg     <= 1'b0;
      cap_idx_pend_reg <= '0;
      loc_w_reg        <= INIT_LOC_W;
      loc_b_reg        <= INIT_LOC_B;
      alive_w_reg      <= '1;
      alive_b_reg      <= '1;
      turn_reg         <= WHITE;
      ply_reg          <= '0;
      status_reg       <= ST_OK;
      captured_reg     <= 1'b0;
      captured_idx_reg <= '0;
`ifdef BOARD_UNDO_EN
      hist_valid_reg   <= 1'b0;
      hist_player_reg  <= WHITE;
      hist_piece_reg   <= '0;
      hist_old_sq_reg  <= '0;
      hist_cap_reg     <= 1'b0;
      hist_cap_idx_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (move_valid) begin
            player_reg <= move_player;
            piece_reg  <= move_piece;
            dst_reg    <= move_dst;
          end
        end
        S_CHECK: begin
          chk_status_reg   <= chk_status_next;
          cap_pend_reg     <= opp_any;
          cap_idx_pend_reg <= opp_low_idx;
        end
        S_COMMIT: begin
          status_reg       <= chk_status_reg;
          captured_reg     <= 1'b0;
          captured_idx_reg <= '0;
          if (chk_status_reg == ST_OK) begin
            if (player_reg == WHITE) begin
              loc_w_reg[piece_reg*SQ_W +: SQ_W] <= dst_reg;
              if (cap_pend_reg) alive_b_reg[cap_idx_pend_reg] <= 1'b0;
            end else begin
              loc_b_reg[piece_reg*SQ_W +: SQ_W] <= dst_reg;
              if (cap_pend_reg) alive_w_reg[cap_idx_pend_reg] <= 1'b0;
            end
            if (cap_pend_reg) begin
              captured_reg     <= 1'b1;
              captured_idx_reg <= cap_idx_pend_reg;
            end
            turn_reg <= ~turn_reg;
            if (ply_reg != '1) ply_reg <= ply_reg + CNT_W'(1);
`ifdef BOARD_UNDO_EN
            hist_valid_reg   <= 1'b1;
            hist_player_reg  <= player_reg;
            hist_piece_reg   <= piece_reg;
            hist_old_sq_reg  <= own_loc[piece_reg*SQ_W +: SQ_W];
            hist_cap_reg     <= cap_pend_reg;
            hist_cap_idx_reg <= cap_idx_pend_reg;
`endif
          end
        end
`ifdef BOARD_UNDO_EN
        S_UNDO: begin
          captured_reg     <= 1'b0;
          captured_idx_reg <= '0;
          if (hist_valid_reg) begin
            status_reg <= ST_OK;
            if (hist_player_reg == WHITE) begin
              loc_w_reg[hist_piece_reg*SQ_W +: SQ_W] <= hist_old_sq_reg;
              if (hist_cap_reg) alive_b_reg[hist_cap_idx_reg] <= 1'b1;
            end else begin
              loc_b_reg[hist_piece_reg*SQ_W +: SQ_W] <= hist_old_sq_reg;
              if (hist_cap_reg) alive_w_reg[hist_cap_idx_reg] <= 1'b1;
            end
            turn_reg <= ~turn_reg;
            if (ply_reg != '0) ply_reg <= ply_reg - CNT_W'(1);
            hist_valid_reg <= 1'b0;
          end else begin
            status_reg <= ST_DEAD_PIECE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign move_ready   = (state_reg == S_IDLE);
`ifdef BOARD_UNDO_EN
  assign undo_ready   = (state_reg == S_IDLE) && hist_valid_reg;
`endif
  assign done         = (state_reg == S_REPORT);
  assign loc_w        = loc_w_reg;
  assign loc_b        = loc_b_reg;
  assign alive_w      = alive_w_reg;
  assign alive_b      = alive_b_reg;
  assign turn         = turn_reg;
  assign status       = status_reg;
  assign captured     = captured_reg;
  assign captured_idx = captured_idx_reg;
  assign ply_count    = ply_reg;
  assign dbg_state    = state_reg[1:0];

endmodule

// File: tb/tb_board_update_gen.sv
// Directed bench for board_update_gen: handshake latency, legality codes, captures,
// stale-location immunity, mid-operation reset and (with BOARD_UNDO_EN) undo.
module tb_board_update_gen;

  localparam logic [95:0] INIT_W = 96'h20928B30D38F0070460850C4;
  localparam logic [95:0] INIT_B = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  logic        clk = 1'b0;
  logic        RST;
  logic        move_valid;
  logic        move_ready;
  logic        move_player;
  logic [3:0]  move_piece;
  logic [5:0]  move_dst;
  logic [95:0] loc_w, loc_b;
  logic [15:0] alive_w, alive_b;
  logic        turn, done, captured;
  logic [1:0]  status, dbg_state;
  logic [3:0]  captured_idx;
  logic [15:0] ply_count;
`ifdef BOARD_UNDO_EN
  logic        undo_req;
  logic        undo_ready;
`endif

  int total = 0;
  int bad   = 0;
  logic [1:0] r_status;
  logic       r_captured;
  logic [3:0] r_cidx;
  int         done_seen;

  always #5 clk = ~clk;

  board_update_gen dut (
    .clk          (clk),
    .RST          (RST),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_player  (move_player),
    .move_piece   (move_piece),
    .move_dst     (move_dst),
`ifdef BOARD_UNDO_EN
    .undo_req     (undo_req),
    .undo_ready   (undo_ready),
`endif
    .loc_w        (loc_w),
    .loc_b        (loc_b),
    .alive_w      (alive_w),
    .alive_b      (alive_b),
    .turn         (turn),
    .done         (done),
    .status       (status),
    .captured     (captured),
    .captured_idx (captured_idx),
    .ply_count    (ply_count),
    .dbg_state    (dbg_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    move_valid = 1'b0;
`ifdef BOARD_UNDO_EN
    undo_req = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
  endtask

  // Presents a move in cycle N and walks the fixed N+1..N+4 window, latching the report.
  task automatic do_move(input logic pl, input logic [3:0] pc, input logic [5:0] dst);
    move_player = pl;
    move_piece  = pc;
    move_dst    = dst;
    move_valid  = 1'b1;
    chk("ready_at_accept", move_ready, 1'b1);
    @(negedge clk);
    move_valid = 1'b0;
    chk("ready_low_n1", move_ready, 1'b0);
    chk("done_low_n1", done, 1'b0);
    @(negedge clk);
    chk("ready_low_n2", move_ready, 1'b0);
    chk("done_low_n2", done, 1'b0);
    @(negedge clk);
    chk("ready_low_n3", move_ready, 1'b0);
    chk("done_at_n3", done, 1'b1);
    r_status   = status;
    r_captured = captured;
    r_cidx     = captured_idx;
    @(negedge clk);
    chk("done_low_n4", done, 1'b0);
    chk("ready_back_n4", move_ready, 1'b1);
    $display("move player=%0d piece=%0d dst=%0d -> status=%0d captured=%0d idx=%0d turn=%0d ply=%0d",
             pl, pc, dst, r_status, r_captured, r_cidx, turn, ply_count);
  endtask

`ifdef BOARD_UNDO_EN
  task automatic do_undo();
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    chk("undo_done_low_n1", done, 1'b0);
    @(negedge clk);
    chk("undo_done_at_n2", done, 1'b1);
    r_status   = status;
    r_captured = captured;
    r_cidx     = captured_idx;
    @(negedge clk);
    chk("undo_done_low_n3", done, 1'b0);
    $display("undo -> status=%0d captured=%0d turn=%0d ply=%0d", r_status, r_captured, turn, ply_count);
  endtask
`endif

  initial begin
    move_player = 1'b0;
    move_piece  = '0;
    move_dst    = '0;
    do_reset();

    // Reset state
    chk("rst_turn", turn, 1'b1);
    chk("rst_alive_w", alive_w, 16'hFFFF);
    chk("rst_alive_b", alive_b, 16'hFFFF);
    chk("rst_locw_p15", loc_w[95:90], 6'd8);
    chk("rst_locb_p15", loc_b[95:90], 6'd48);
    chk("rst_locw_k1", loc_w[5:0], 6'd4);
    chk("rst_ply", ply_count, 16'd0);
    chk("rst_ready", move_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'd0);
    chk("rst_captured", captured, 1'b0);
    chk("rst_cidx", captured_idx, 4'd0);
    chk("rst_state", dbg_state, 2'd0);

    // Plain white move, then black move onto its own square
    do_move(1'b1, 4'd15, 6'd16);
    chk("w15_status", r_status, 2'd0);
    chk("w15_captured", r_captured, 1'b0);
    chk("w15_loc", loc_w[95:90], 6'd16);
    chk("w15_turn", turn, 1'b0);
    chk("w15_ply", ply_count, 16'd1);
    do_move(1'b0, 4'd0, 6'd60);
    chk("same_sq_status", r_status, 2'd0);
    chk("same_sq_captured", r_captured, 1'b0);
    chk("same_sq_loc", loc_b[5:0], 6'd60);
    chk("same_sq_turn", turn, 1'b1);
    chk("same_sq_ply", ply_count, 16'd2);

    // Wrong side to move
    do_reset();
    do_move(1'b0, 4'd15, 6'd40);
    chk("wt_status", r_status, 2'd1);
    chk("wt_locb", loc_b, INIT_B);
    chk("wt_locw", loc_w, INIT_W);
    chk("wt_turn", turn, 1'b1);
    chk("wt_ply", ply_count, 16'd0);

    // Capture, dead-piece rejection, stale square not recaptured
    do_reset();
    do_move(1'b1, 4'd15, 6'd48);
    chk("cap_status", r_status, 2'd0);
    chk("cap_flag", r_captured, 1'b1);
    chk("cap_idx", r_cidx, 4'd15);
    chk("cap_alive_b", alive_b, 16'h7FFF);
    chk("cap_loc", loc_w[95:90], 6'd48);
    chk("cap_turn", turn, 1'b0);
    do_move(1'b0, 4'd15, 6'd40);
    chk("dead_status", r_status, 2'd2);
    chk("dead_captured", r_captured, 1'b0);
    chk("dead_turn", turn, 1'b0);
    chk("dead_ply", ply_count, 16'd1);
    chk("dead_locb", loc_b, INIT_B);
    do_move(1'b0, 4'd14, 6'd20);
    chk("b14_status", r_status, 2'd0);
    do_move(1'b1, 4'd15, 6'd30);
    chk("w15b_status", r_status, 2'd0);
    do_move(1'b0, 4'd13, 6'd21);
    chk("b13_status", r_status, 2'd0);
    do_move(1'b1, 4'd14, 6'd48);
    chk("stale_status", r_status, 2'd0);
    chk("stale_captured", r_captured, 1'b0);
    chk("stale_alive_b", alive_b, 16'h7FFF);
    chk("stale_loc", loc_w[89:84], 6'd48);
    chk("stale_ply", ply_count, 16'd5);

    // Self-capture, then reset during CHECK of the next move
    do_reset();
    do_move(1'b1, 4'd15, 6'd4);
    chk("self_status", r_status, 2'd3);
    chk("self_locw", loc_w, INIT_W);
    chk("self_turn", turn, 1'b1);
    chk("self_ply", ply_count, 16'd0);
    move_player = 1'b1;
    move_piece  = 4'd15;
    move_dst    = 6'd16;
    move_valid  = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    chk("abort_in_check", dbg_state, 2'd1);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_locw", loc_w, INIT_W);
    chk("abort_turn", turn, 1'b1);
    chk("abort_ply", ply_count, 16'd0);
    chk("abort_status", status, 2'd0);
    chk("abort_ready", move_ready, 1'b1);
    chk("abort_state", dbg_state, 2'd0);

`ifdef BOARD_UNDO_EN
    do_reset();
    chk("undo_ready_rst", undo_ready, 1'b0);
    do_move(1'b1, 4'd15, 6'd48);
    chk("undo_pre_cap", r_captured, 1'b1);
    chk("undo_ready_set", undo_ready, 1'b1);
    do_undo();
    chk("undo_status", r_status, 2'd0);
    chk("undo_captured", r_captured, 1'b0);
    chk("undo_alive_b", alive_b, 16'hFFFF);
    chk("undo_loc", loc_w[95:90], 6'd8);
    chk("undo_turn", turn, 1'b1);
    chk("undo_ply", ply_count, 16'd0);
    chk("undo_ready_clr", undo_ready, 1'b0);
    do_undo();
    chk("undo2_status", r_status, 2'd2);
    chk("undo2_locw", loc_w, INIT_W);
    chk("undo2_turn", turn, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
